// File: rtl/alpha_blend_pipe_if.sv
// Operand/result handshake bundle for alpha_blend_pipe: issue side (in_*) and
// retire side (out_*), each with its own valid/ready pair.
interface alpha_blend_pipe_if #(
  parameter int LANES = 16,
  parameter int W     = 8,
  parameter int TAGW  = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_mode;
  logic [LANES*W-1:0] in_a;
  logic [LANES*W-1:0] in_b;
  logic [LANES*W-1:0] in_alpha;
  logic [TAGW-1:0]    in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] out_res;
  logic [TAGW-1:0]    out_tag;

  modport master (
    output in_valid, in_mode, in_a, in_b, in_alpha, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, in_alpha, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag
  );
endinterface

// File: rtl/alpha_blend_pipe.sv
// Three-stage vector execute unit: per-lane alpha blend, saturating add/sub and
// pass-through, with a single global advance, flush and a tag carried per op.
module alpha_blend_pipe #(
  parameter int LANES = 16,
  parameter int W     = 8,
  parameter int TAGW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  alpha_blend_pipe_if.slave bus,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    MODE_BLEND   = 2'b00,
    MODE_SAT_ADD = 2'b01,
    MODE_SAT_SUB = 2'b10,
    MODE_PASS    = 2'b11
  } mode_e;

  localparam int            QW         = 2*W + 1;
  localparam logic [W-1:0]  FULL       = {W{1'b1}};
  localparam logic [QW-1:0] ROUND_BIAS = {{(W+1){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [QW-1:0] FULL_Q     = {{(W+1){1'b0}}, FULL};

  logic            adv;
  logic            v1_reg, v2_reg, v3_reg;
  mode_e           mode1_reg, mode2_reg;
  logic [TAGW-1:0] tag1_reg, tag2_reg, tag3_reg;

  logic [LANES*2*W-1:0] x_next, x_reg;
  logic [LANES*2*W-1:0] y_next, y_reg;
  logic [LANES*QW-1:0]  q_next, q_reg;
  logic [LANES*W-1:0]   res_next, res_reg;

  // Whole pipe moves as one; a full S3 only blocks when downstream refuses it.
  assign adv          = !v3_reg | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v3_reg;
  assign bus.out_res   = res_reg;
  assign bus.out_tag   = tag3_reg;
  assign occupancy     = {1'b0, v1_reg} + {1'b0, v2_reg} + {1'b0, v3_reg};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   alpha;
    logic [2*W-1:0] lane_x;
    logic [2*W-1:0] lane_y;
    logic [2*W-1:0] x_cur;
    logic [2*W-1:0] y_cur;
    logic [QW-1:0]  lane_q;
    logic [QW-1:0]  q_cur;
    logic [W-1:0]   lane_r;

    assign a     = bus.in_a[gi*W +: W];
    assign b     = bus.in_b[gi*W +: W];
    assign alpha = bus.in_alpha[gi*W +: W];
    assign x_cur = x_reg[gi*2*W +: 2*W];
    assign y_cur = y_reg[gi*2*W +: 2*W];
    assign q_cur = q_reg[gi*QW +: QW];

    // S1: products for blend; the other modes finish their arithmetic here.
    always_comb begin
      lane_x = '0;
      lane_y = '0;
      case (mode_e'(bus.in_mode))
        MODE_BLEND: begin
          lane_x = {{W{1'b0}}, a} * {{W{1'b0}}, alpha};
          lane_y = {{W{1'b0}}, b} * {{W{1'b0}}, FULL - alpha};
        end
        MODE_SAT_ADD: lane_x = {{(W-1){1'b0}}, {1'b0, a} + {1'b0, b}};
        MODE_SAT_SUB: lane_x = (a < b) ? '0 : {{W{1'b0}}, a - b};
        default:      lane_x = {{W{1'b0}}, a};
      endcase
    end

    // S2: blend sum with half-LSB rounding bias; other modes just carry.
    always_comb begin
      lane_q = {1'b0, x_cur};
      if (mode1_reg == MODE_BLEND) begin
        lane_q = {1'b0, x_cur} + {1'b0, y_cur} + ROUND_BIAS;
      end
    end

    // S3: (q + q>>W) >> W divides by 2**W-1 rather than 2**W.
    always_comb begin
      lane_r = q_cur[W-1:0];
      if (mode2_reg == MODE_BLEND) begin
        lane_r = W'((q_cur + (q_cur >> W)) >> W);
      end else if (mode2_reg == MODE_SAT_ADD && q_cur > FULL_Q) begin
        lane_r = FULL;
      end
    end

    assign x_next[gi*2*W +: 2*W] = lane_x;
    assign y_next[gi*2*W +: 2*W] = lane_y;
    assign q_next[gi*QW +: QW]   = lane_q;
    assign res_next[gi*W +: W]   = lane_r;
  end

  // Flush outranks both the incoming op and the advance; data may go stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else if (flush) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else if (adv) begin
      v1_reg <= bus.in_valid;
      v2_reg <= v1_reg;
      v3_reg <= v2_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg     <= '0;
      y_reg     <= '0;
      q_reg     <= '0;
      res_reg   <= '0;
      mode1_reg <= MODE_BLEND;
      mode2_reg <= MODE_BLEND;
      tag1_reg  <= '0;
      tag2_reg  <= '0;
      tag3_reg  <= '0;
    end else if (adv) begin
      x_reg     <= x_next;
      y_reg     <= y_next;
      q_reg     <= q_next;
      res_reg   <= res_next;
      mode1_reg <= mode_e'(bus.in_mode);
      mode2_reg <= mode1_reg;
      tag1_reg  <= bus.in_tag;
      tag2_reg  <= tag1_reg;
      tag3_reg  <= tag2_reg;
    end
  end

endmodule

// File: tb/tb_alpha_blend_pipe.sv
// Directed bench for alpha_blend_pipe: a vector table for the arithmetic plus
// hand-written sequences for streaming, backpressure, flush and async reset.
module tb_alpha_blend_pipe;
  localparam int LANES = 16;
  localparam int W     = 8;
  localparam int TAGW  = 4;
  localparam int VW    = LANES * W;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] occupancy;

  alpha_blend_pipe_if #(.LANES(LANES), .W(W), .TAGW(TAGW)) bus ();

  alpha_blend_pipe #(.LANES(LANES), .W(W), .TAGW(TAGW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [1:0]      mode;
    logic [VW-1:0]   a;
    logic [VW-1:0]   b;
    logic [VW-1:0]   alpha;
    logic [TAGW-1:0] tag;
    logic [VW-1:0]   exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: nearest integer to p/255 (p/255 is never exactly .5).
  function automatic logic [7:0] blend_ref(input int a, input int b, input int al);
    int p;
    p = a * al + b * (255 - al);
    return 8'((2 * p + 255) / 510);
  endfunction

  function automatic vec_t mk(input string name, input logic [1:0] mode, input logic [7:0] a8,
                              input logic [7:0] b8, input logic [7:0] al8,
                              input logic [TAGW-1:0] tag, input logic [7:0] ex8);
    vec_t v;
    v.name  = name;
    v.mode  = mode;
    v.a     = {LANES{a8}};
    v.b     = {LANES{b8}};
    v.alpha = {LANES{al8}};
    v.tag   = tag;
    v.exp   = {LANES{ex8}};
    return v;
  endfunction

  task automatic drive(input logic [1:0] mode, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic [VW-1:0] al, input logic [TAGW-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_alpha = al;
    bus.in_tag   = tag;
  endtask

  task automatic run_one(input vec_t v);
    int lat;
    @(negedge clk);
    drive(v.mode, v.a, v.b, v.alpha, v.tag);
    chk({v.name, " in_ready"}, int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, " latency"}, lat, 3);
    chk({v.name, " tag"}, int'(bus.out_tag), int'(v.tag));
    for (int l = 0; l < LANES; l++) begin
      chk($sformatf("%s lane%0d", v.name, l), int'(bus.out_res[l*W +: W]), int'(v.exp[l*W +: W]));
    end
    $display("op %-16s tag %0d latency %0d res %h", v.name, bus.out_tag, lat, bus.out_res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t           m;
    int             got_tag[$];
    int             got_cyc[$];
    logic [VW-1:0]  got_res[$];
    logic [VW-1:0]  hold_res;
    int             hold_tag;
    int             seen;

    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'b00;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_alpha  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    vecs.push_back(mk("blend a255",   2'b00, 8'h80, 8'h10, 8'hFF, 4'h1, 8'h80));
    vecs.push_back(mk("blend a0",     2'b00, 8'h37, 8'hC5, 8'h00, 4'h2, 8'hC5));
    vecs.push_back(mk("blend a128",   2'b00, 8'hFF, 8'h00, 8'h80, 4'h3, 8'h80));
    vecs.push_back(mk("blend a64",    2'b00, 8'hFF, 8'h00, 8'h40, 4'h5, 8'h40));
    vecs.push_back(mk("satadd 200+100", 2'b01, 8'hC8, 8'h64, 8'h11, 4'h6, 8'hFF));
    vecs.push_back(mk("satadd 10+20", 2'b01, 8'h0A, 8'h14, 8'h22, 4'h7, 8'h1E));
    vecs.push_back(mk("satadd 128+127", 2'b01, 8'h80, 8'h7F, 8'h00, 4'hB, 8'hFF));
    vecs.push_back(mk("satsub 50-100", 2'b10, 8'h32, 8'h64, 8'h44, 4'h8, 8'h00));
    vecs.push_back(mk("satsub 100-50", 2'b10, 8'h64, 8'h32, 8'h55, 4'h9, 8'h32));
    vecs.push_back(mk("pass a",       2'b11, 8'h5A, 8'hFF, 8'h33, 4'hA, 8'h5A));

    m.name = "blend mixed";
    m.mode = 2'b00;
    m.tag  = 4'h4;
    for (int l = 0; l < LANES; l++) begin
      logic [7:0] a8, b8, al8;
      a8  = 8'(l * 17 + 5);
      b8  = 8'(250 - l * 13);
      al8 = (l == 0) ? 8'h00 : (l == LANES - 1) ? 8'hFF : 8'(l * 16 + 7);
      m.a[l*W +: W]     = a8;
      m.b[l*W +: W]     = b8;
      m.alpha[l*W +: W] = al8;
      m.exp[l*W +: W]   = blend_ref(int'(a8), int'(b8), int'(al8));
    end
    vecs.push_back(m);

    // Asynchronous reset takes effect before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset occupancy", int'(occupancy), 0);
    chk("reset out_tag", int'(bus.out_tag), 0);
    chk_vec("reset out_res", bus.out_res, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_one(vecs[i]);

    // Back-to-back stream of 8 ops.
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got_tag.push_back(int'(bus.out_tag));
        got_cyc.push_back(c);
        got_res.push_back(bus.out_res);
      end
      if (c < 8) drive(2'b11, {LANES{8'(c * 3 + 1)}}, '0, '0, 4'(c + 1));
      else bus.in_valid = 1'b0;
    end
    chk("stream count", got_tag.size(), 8);
    if (got_cyc.size() > 0) chk("stream first cycle", got_cyc[0], 3);
    for (int i = 0; i < got_tag.size() && i < 8; i++) begin
      chk($sformatf("stream tag%0d", i), got_tag[i], i + 1);
      chk($sformatf("stream cycle%0d", i), got_cyc[i], got_cyc[0] + i);
      chk_vec($sformatf("stream res%0d", i), got_res[i], {LANES{8'(i * 3 + 1)}});
      $display("stream op %0d tag %0d cycle %0d", i, got_tag[i], got_cyc[i]);
    end

    // Backpressure: three ops fill the pipe while out_ready=0.
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, {LANES{8'(8'hA0 + c)}}, '0, '0, 4'(4'hA + c));
      @(negedge clk);
    end
    drive(2'b11, {LANES{8'hEE}}, '0, '0, 4'hF);
    hold_tag = int'(bus.out_tag);
    hold_res = bus.out_res;
    chk("stall head tag", hold_tag, 4'hA);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d in_ready", c), int'(bus.in_ready), 0);
      chk($sformatf("stall%0d occupancy", c), int'(occupancy), 3);
      chk($sformatf("stall%0d out_valid", c), int'(bus.out_valid), 1);
      chk($sformatf("stall%0d out_tag", c), int'(bus.out_tag), hold_tag);
      chk_vec($sformatf("stall%0d out_res", c), bus.out_res, hold_res);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    got_tag.delete();
    got_res.delete();
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) begin
        got_tag.push_back(int'(bus.out_tag));
        got_res.push_back(bus.out_res);
      end
      @(negedge clk);
    end
    chk("release count", got_tag.size(), 3);
    for (int i = 0; i < got_tag.size() && i < 3; i++) begin
      chk($sformatf("release tag%0d", i), got_tag[i], 4'hA + i);
      chk_vec($sformatf("release res%0d", i), got_res[i], {LANES{8'(8'hA0 + i)}});
      $display("release op %0d tag %0d", i, got_tag[i]);
    end

    // Flush with two ops in flight and a third offered the same cycle.
    drive(2'b11, {LANES{8'h31}}, '0, '0, 4'h3);
    @(negedge clk);
    drive(2'b11, {LANES{8'h41}}, '0, '0, 4'h4);
    @(negedge clk);
    chk("preflush occupancy", int'(occupancy), 2);
    drive(2'b11, {LANES{8'h51}}, '0, '0, 4'h5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush out_valid", int'(bus.out_valid), 0);
    chk("flush occupancy", int'(occupancy), 0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("flushed ops emerging", seen, 0);
    $display("flush sequence done, %0d results after flush", seen);

    // Asynchronous reset mid-stream, between clock edges.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(2'b11, {LANES{8'(8'h61 + c)}}, '0, '0, 4'(4'h6 + c));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("prereset out_valid", int'(bus.out_valid), 1);
    chk("prereset out_tag", int'(bus.out_tag), 4'h6);
    #2 rst = 1'b0;
    #1;
    chk("midreset out_valid", int'(bus.out_valid), 0);
    chk("midreset in_ready", int'(bus.in_ready), 1);
    chk("midreset occupancy", int'(occupancy), 0);
    chk("midreset out_tag", int'(bus.out_tag), 0);
    chk_vec("midreset out_res", bus.out_res, '0);
    $display("mid-stream reset applied");
    @(negedge clk);
    rst = 1'b1;
    run_one(mk("post-reset blend", 2'b00, 8'h80, 8'h10, 8'hFF, 4'hC, 8'h80));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
